// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multicycle ALU control path: ALU ops, operand
// selects, instruction fields and the sequencer state enum.
package alu_ctrl_pkg;

  localparam int OPW    = 6;
  localparam int ALUOPW = 3;

  typedef enum logic [ALUOPW-1:0] {
    ALU_NOP = 3'b000,
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_SLT = 3'b111
  } alu_op_e;

  localparam logic       SRC_A_PC      = 1'b0;
  localparam logic       SRC_A_REG     = 1'b1;
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPW-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPW-1:0] OP_ORI   = 6'h0D;

  localparam logic [OPW-1:0] FN_ADD = 6'h20;
  localparam logic [OPW-1:0] FN_SUB = 6'h22;
  localparam logic [OPW-1:0] FN_AND = 6'h24;
  localparam logic [OPW-1:0] FN_OR  = 6'h25;
  localparam logic [OPW-1:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EX_R,
    ST_EX_I,
    ST_EX_BEQ,
    ST_WB,
    ST_ERR
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation decode from sequencer state and instruction
// fields; valid flags whether the opcode/funct pair is supported.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  state_e             state,
  input  logic [OPW-1:0]     opcode,
  input  logic [OPW-1:0]     funct,
  output logic [ALUOPW-1:0]  alu_op,
  output logic               valid
);

  alu_op_e ex_op;

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ex_op = ALU_NOP;
    valid = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD:  begin ex_op = ALU_ADD; valid = 1'b1; end
          FN_SUB:  begin ex_op = ALU_SUB; valid = 1'b1; end
          FN_AND:  begin ex_op = ALU_AND; valid = 1'b1; end
          FN_OR:   begin ex_op = ALU_OR;  valid = 1'b1; end
          FN_SLT:  begin ex_op = ALU_SLT; valid = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin ex_op = ALU_ADD; valid = 1'b1; end
      OP_ANDI: begin ex_op = ALU_AND; valid = 1'b1; end
      OP_ORI:  begin ex_op = ALU_OR;  valid = 1'b1; end
      OP_BEQ:  begin ex_op = ALU_SUB; valid = 1'b1; end
      default: ;
    endcase
  end

  // FETCH and DECODE reuse the ALU as an adder (PC+4, branch target); WB
  // holds the execute op so the result stays stable during the write.
  always_comb begin
    alu_op = ALU_NOP;
    unique case (state)
      ST_FETCH, ST_DECODE:   alu_op = ALU_ADD;
      ST_EX_R, ST_EX_I, ST_WB: alu_op = ex_op;
      ST_EX_BEQ:             alu_op = ALU_SUB;
      default:               alu_op = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/alu_src_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer driving the ALU operand
// muxes, ALU op and the PC/IR/register-file write strobes.
module alu_src_sequencer
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [OPW-1:0]    opcode,
  input  logic [OPW-1:0]    funct,
  input  logic              zero,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic              ir_write,
  output logic              pc_write,
  output logic              reg_write,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e         state, state_nxt;
  logic [OPW-1:0] op_q, funct_q;
  logic [OPW-1:0] dec_opcode, dec_funct;
  logic           dec_valid;

  // The IR fields are only trusted during DECODE; afterwards the latched
  // copies drive the decode so late IR changes cannot alter the instruction.
  always_comb begin
    dec_opcode = op_q;
    dec_funct  = funct_q;
    if (state == ST_DECODE) begin
      dec_opcode = opcode;
      dec_funct  = funct;
    end
  end

  alu_op_decode u_alu_op_decode (
    .state  (state),
    .opcode (dec_opcode),
    .funct  (dec_funct),
    .alu_op (alu_op),
    .valid  (dec_valid)
  );

  // NOTE: state and the small field latches are cleared asynchronously so the
  // Moore strobes drop the instant reset_n falls, without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      funct_q <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == ST_WB) || (state == ST_EX_BEQ) || (state == ST_ERR);
      err   <= (state == ST_ERR);
      if (state == ST_DECODE) begin
        op_q    <= opcode;
        funct_q <= funct;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (!dec_valid)             state_nxt = ST_ERR;
        else if (opcode == OP_RTYPE) state_nxt = ST_EX_R;
        else if (opcode == OP_BEQ)   state_nxt = ST_EX_BEQ;
        else                         state_nxt = ST_EX_I;
      end
      ST_EX_R, ST_EX_I: state_nxt = ST_WB;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_REG;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    busy      = (state != ST_IDLE);
    unique case (state)
      ST_FETCH: begin
        alu_src_b = SRC_B_FOUR;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
      end
      ST_DECODE: alu_src_b = SRC_B_IMM_SH2;
      ST_EX_R: alu_src_a = SRC_A_REG;
      ST_EX_I: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
      end
      ST_EX_BEQ: begin
        alu_src_a = SRC_A_REG;
        pc_write  = zero;
      end
      ST_WB: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = (op_q == OP_RTYPE) ? SRC_B_REG : SRC_B_IMM;
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_src_sequencer.sv
// Directed bench for alu_src_sequencer: every output is packed into one
// vector per cycle and compared with hand-derived expectations.
module tb_alu_src_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       ir_write, pc_write, reg_write, busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_src_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Layout: {a, b[1:0], op[2:0], ir, pc, rw, busy, done, err}
  function automatic logic [11:0] vec(input logic a, input logic [1:0] b,
                                      input logic [2:0] op, input logic ir,
                                      input logic pc, input logic rw,
                                      input logic bsy, input logic dn,
                                      input logic er);
    return {a, b, op, ir, pc, rw, bsy, dn, er};
  endfunction

  localparam logic [11:0] V_IDLE   = 12'b0_00_000_000000;
  localparam logic [11:0] V_FETCH  = 12'b0_01_001_110100;
  localparam logic [11:0] V_DECODE = 12'b0_11_001_000100;
  localparam logic [11:0] V_DONE   = 12'b0_00_000_000010;
  localparam logic [11:0] V_DONE_E = 12'b0_00_000_000011;
  localparam logic [11:0] V_ERR    = 12'b0_00_000_000100;

  task automatic check(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [11:0] exp);
    check(tag, {alu_src_a, alu_src_b, alu_op, ir_write, pc_write, reg_write,
                busy, done, err}, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    opcode  = 6'h00;
    funct   = 6'h00;
    zero    = 1'b0;
    #2;
    expect_out("reset_idle", V_IDLE);
    step();
    reset_n = 1'b1;
    step();
    expect_out("idle_after_reset", V_IDLE);

    // R-type add; opcode/funct corrupted after DECODE must not matter
    opcode = 6'h00; funct = 6'h20; start = 1'b1;
    step(); start = 1'b0;
    expect_out("add_fetch", V_FETCH);
    step();
    expect_out("add_decode", V_DECODE);
    step(); opcode = 6'h3F; funct = 6'h03;
    expect_out("add_ex_r", vec(1, 2'b00, 3'b001, 0, 0, 0, 1, 0, 0));
    step();
    expect_out("add_wb", vec(1, 2'b00, 3'b001, 0, 0, 1, 1, 0, 0));
    step();
    expect_out("add_done", V_DONE);
    step();
    expect_out("add_idle", V_IDLE);

    // addi then ori back to back with start held high
    opcode = 6'h08; start = 1'b1;
    step();
    expect_out("addi_fetch", V_FETCH);
    step();
    expect_out("addi_decode", V_DECODE);
    step(); opcode = 6'h0D;
    expect_out("addi_ex_i", vec(1, 2'b10, 3'b001, 0, 0, 0, 1, 0, 0));
    step();
    expect_out("addi_wb", vec(1, 2'b10, 3'b001, 0, 0, 1, 1, 0, 0));
    step();
    expect_out("addi_done", V_DONE);
    step();
    expect_out("ori_fetch", V_FETCH);
    step(); start = 1'b0;
    expect_out("ori_decode", V_DECODE);
    step();
    expect_out("ori_ex_i", vec(1, 2'b10, 3'b100, 0, 0, 0, 1, 0, 0));
    step();
    expect_out("ori_wb", vec(1, 2'b10, 3'b100, 0, 0, 1, 1, 0, 0));
    step();
    expect_out("ori_done", V_DONE);
    step();
    expect_out("ori_idle", V_IDLE);

    // beq taken and not taken
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'h04; zero = z[0]; start = 1'b1;
      step(); start = 1'b0;
      expect_out("beq_fetch", V_FETCH);
      step();
      expect_out("beq_decode", V_DECODE);
      step();
      expect_out(z ? "beq_ex_taken" : "beq_ex_not_taken",
                 vec(1, 2'b00, 3'b010, 0, z[0], 0, 1, 0, 0));
      step();
      expect_out("beq_done", V_DONE);
      step();
      expect_out("beq_idle", V_IDLE);
    end
    zero = 1'b0;

    // Illegal opcode, then R-type with unsupported funct
    for (int k = 0; k < 2; k++) begin
      opcode = (k == 0) ? 6'h3F : 6'h00;
      funct  = (k == 0) ? 6'h20 : 6'h03;
      start  = 1'b1;
      step(); start = 1'b0;
      expect_out("bad_fetch", V_FETCH);
      step();
      expect_out("bad_decode", V_DECODE);
      step();
      expect_out("bad_err_state", V_ERR);
      step();
      expect_out("bad_done_err", V_DONE_E);
      step();
      expect_out("bad_idle", V_IDLE);
    end

    // start pulsed while busy is ignored: R-type sub
    opcode = 6'h00; funct = 6'h22; start = 1'b1;
    step(); start = 1'b0;
    expect_out("sub_fetch", V_FETCH);
    step(); start = 1'b1;
    expect_out("sub_decode", V_DECODE);
    step();
    expect_out("sub_ex_r", vec(1, 2'b00, 3'b010, 0, 0, 0, 1, 0, 0));
    step(); start = 1'b0;
    expect_out("sub_wb", vec(1, 2'b00, 3'b010, 0, 0, 1, 1, 0, 0));
    step();
    expect_out("sub_done", V_DONE);
    step();
    expect_out("sub_no_second", V_IDLE);
    step();
    expect_out("sub_still_idle", V_IDLE);

    // Asynchronous reset in the middle of EX_R
    opcode = 6'h00; funct = 6'h25; start = 1'b1;
    step(); start = 1'b0;
    step();
    step();
    expect_out("rst_pre_ex_r", vec(1, 2'b00, 3'b100, 0, 0, 0, 1, 0, 0));
    #2 reset_n = 1'b0;
    #1;
    expect_out("rst_async_clear", V_IDLE);
    step();
    expect_out("rst_held", V_IDLE);
    reset_n = 1'b1;
    step();
    expect_out("rst_no_wb", V_IDLE);
    step();
    expect_out("rst_no_done", V_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
